// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data RAM access controller
// Byte/halfword/word loads and stores over a shared tri-state bus; sub-word stores use read-modify-write.
module mem_access_ctrl #(
  parameter int ADDR_W      = 12,
  parameter bit BYTE_LITTLE = 1'b1
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [31:0]       ram_data,
  output logic              ram_rw,
  output logic              ram_cs
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] WR    = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]        state;
  logic              op_we;
  logic [1:0]        op_size;
  logic              op_sext;
  logic [ADDR_W+1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [31:0]       word_q;

  logic              misaligned;
  logic [4:0]        byte_sh;
  logic [4:0]        half_sh;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  // Address bits above the RAM word index are don't-care.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = (addr[1:0] != 2'b00);
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  end

  // Bit offset of the addressed lane inside the 32-bit word; big-endian mirrors the index.
  assign byte_sh = BYTE_LITTLE ? {op_addr[1:0], 3'b000} : {~op_addr[1:0], 3'b000};
  assign half_sh = BYTE_LITTLE ? {op_addr[1], 4'b0000} : {~op_addr[1], 4'b0000};

  assign rd_byte = ram_data[byte_sh +: 8];
  assign rd_half = ram_data[half_sh +: 16];

  always_comb begin
    load_val = ram_data;
    case (op_size)
      SZ_BYTE: load_val = {{24{op_sext & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_val = {{16{op_sext & rd_half[15]}}, rd_half};
      default: load_val = ram_data;
    endcase
  end

  always_comb begin
    merged = op_wdata;
    case (op_size)
      SZ_BYTE: begin
        merged = word_q;
        merged[byte_sh +: 8] = op_wdata[7:0];
      end
      SZ_HALF: begin
        merged = word_q;
        merged[half_sh +: 16] = op_wdata[15:0];
      end
      default: merged = op_wdata;
    endcase
  end

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      op_we    <= 1'b0;
      op_size  <= 2'b00;
      op_sext  <= 1'b0;
      op_addr  <= '0;
      op_wdata <= 32'h0;
      word_q   <= 32'h0;
      rdata    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_we    <= we;
            op_size  <= size;
            op_sext  <= sext;
            op_addr  <= addr[ADDR_W+1:0];
            op_wdata <= wdata;
            if (misaligned)
              state <= FAULT;
            else if (we && size == SZ_WORD)
              state <= WR;
            else
              state <= RD;
          end
        end
        RD: begin
          word_q <= ram_data;
          if (op_we) begin
            state <= WR;
          end else begin
            rdata <= load_val;
            state <= DONE;
          end
        end
        WR:      state <= DONE;
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus direction comes only from the registered state so drive and ram_rw always agree.
  assign ram_cs   = (state == RD) || (state == WR);
  assign ram_rw   = (state == WR);
  assign ram_addr = op_addr[ADDR_W+1:2];
  assign ram_data = (state == WR) ? merged : 32'bz;
  assign done     = (state == DONE) || (state == FAULT);
  assign err      = (state == FAULT);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
// Directed test-plan steps then random traffic, compared against a word-array reference model.
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        Rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic [11:0] ram_addr;
  wire  [31:0] ram_data;
  logic        ram_rw;
  logic        ram_cs;

  logic [31:0] mem [4096] = '{default: 32'h0};
  logic [31:0] ref_mem [4096] = '{default: 32'h0};
  logic [31:0] ref_rdata = 32'h0;
  logic [31:0] exp_wr_word = 32'h0;
  logic        mon_en = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  mem_access_ctrl #(.ADDR_W(12), .BYTE_LITTLE(1'b1)) dut (
    .CLK(CLK), .Rst(Rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data), .ram_rw(ram_rw),
    .ram_cs(ram_cs)
  );

  always #5 CLK = ~CLK;

  // RAM: drives the bus whenever ram_rw is low, commits writes on the clock edge.
  assign ram_data = (ram_rw == 1'b0) ? mem[ram_addr] : 32'bz;
  always @(posedge CLK) if (ram_cs && ram_rw) mem[ram_addr] <= ram_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      chk("bus_no_x", 32'($isunknown(ram_data)), 32'd0);
      chk("rw_implies_cs", 32'(ram_rw && !ram_cs), 32'd0);
      if (ram_cs && !ram_rw) rd_cnt++;
      if (ram_cs && ram_rw) begin
        wr_cnt++;
        chk("wr_bus_word", ram_data, exp_wr_word);
      end
    end
  end

  function automatic logic model_misaligned(logic [1:0] sz, logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic sx);
    int off;
    logic [31:0] v;
    v = w;
    if (sz == 2'd0) begin
      off = int'(a % 4);
      v = (w >> (8 * off)) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      off = int'((a / 2) % 2);
      v = (w >> (16 * off)) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
    int off;
    logic [31:0] mask;
    if (sz == 2'd0) begin
      off = int'(a % 4);
      mask = 32'hFF << (8 * off);
      return (w & ~mask) | ((wd & 32'hFF) << (8 * off));
    end else if (sz == 2'd1) begin
      off = int'((a / 2) % 2);
      mask = 32'hFFFF << (16 * off);
      return (w & ~mask) | ((wd & 32'hFFFF) << (16 * off));
    end
    return wd;
  endfunction

  task automatic do_op(input logic we_i, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    int idx, lat, exp_lat, exp_rd, exp_wr;
    logic bad;
    logic [31:0] new_w, exp_rdata;
    idx = int'(a[13:2]);
    bad = model_misaligned(sz, a);
    new_w = ref_mem[idx];
    exp_rdata = ref_rdata;
    if (bad) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!we_i) begin
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
      exp_rdata = model_load(ref_mem[idx], a, sz, sx);
    end else if (sz == 2'd2) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 1;
      new_w = wd;
    end else begin
      exp_lat = 3; exp_rd = 1; exp_wr = 1;
      new_w = model_store(ref_mem[idx], a, sz, wd);
    end
    exp_wr_word = new_w;
    @(negedge CLK);
    req = 1'b1; we = we_i; size = sz; sext = sx; addr = a; wdata = wd;
    @(posedge CLK); #1;
    req = 1'b0; rd_cnt = 0; wr_cnt = 0;
    we = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    lat = 1;
    while (done !== 1'b1 && lat < 12) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("err", 32'(err), 32'(bad));
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("rdata", rdata, exp_rdata);
    chk("rd_cycles", 32'(rd_cnt), 32'(exp_rd));
    chk("wr_cycles", 32'(wr_cnt), 32'(exp_wr));
    chk("ram_word", mem[idx], new_w);
    ref_mem[idx] = new_w;
    ref_rdata = exp_rdata;
    @(posedge CLK); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cs", 32'(ram_cs), 32'd0);
    chk("rst_rw", 32'(ram_rw), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    Rst = 1'b0;
    mon_en = 1'b1;

    do_op(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
    chk("plan_word_load", rdata, 32'hDEAD_BEEF);

    do_op(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1122_3344);
    do_op(1'b1, 2'd0, 1'b0, 32'h0000_0012, 32'h0000_00AA);
    chk("plan_byte_rmw", mem[4], 32'h11AA_3344);

    do_op(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h8001_7FFF);
    do_op(1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0);
    chk("plan_half_sext", rdata, 32'hFFFF_8001);
    do_op(1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0);
    chk("plan_half_zext", rdata, 32'h0000_8001);
    do_op(1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0);
    chk("plan_half_pos", rdata, 32'h0000_7FFF);

    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0013, 32'h0);
    chk("plan_misaligned_rdata", rdata, 32'h0000_7FFF);

    // Back-to-back: req held high is re-accepted in the IDLE cycle after DONE.
    @(negedge CLK);
    req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h10;
    @(posedge CLK); #1; chk("b2b_rd1", 32'(ram_cs), 32'd1);
    @(posedge CLK); #1; chk("b2b_done1", 32'(done), 32'd1);
    @(posedge CLK); #1; chk("b2b_idle", 32'(busy), 32'd0);
    @(posedge CLK); #1; chk("b2b_rd2", 32'(ram_cs), 32'd1);
    req = 1'b0;
    @(posedge CLK); #1; chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_rdata", rdata, ref_mem[4]);
    ref_rdata = ref_mem[4];
    @(posedge CLK); #1;

    // Reset during the RD cycle of a sub-word store.
    @(negedge CLK);
    req = 1'b1; we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'h11; wdata = 32'h55;
    @(posedge CLK); #1;
    req = 1'b0;
    chk("mid_rst_in_rd", 32'(ram_cs && !ram_rw), 32'd1);
    Rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cs", 32'(ram_cs), 32'd0);
    chk("mid_rst_rw", 32'(ram_rw), 32'd0);
    chk("mid_rst_rdata", rdata, 32'h0);
    ref_rdata = 32'h0;
    @(negedge CLK);
    Rst = 1'b0;
    @(posedge CLK); #1;
    chk("mid_rst_word_kept", mem[4], ref_mem[4]);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);

    for (int i = 0; i < 40; i++) begin
      do_op(1'($urandom), 2'($urandom), 1'($urandom),
            {$urandom_range(0, 255) << 14} | 32'($urandom_range(0, 63)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side controller that drives the single-port 32-bit data RAM (12-bit word address, shared tri-state data bus, R_W, CS) on behalf of the multicycle CPU's MEM stage.
- Converts CPU byte-addressed load/store requests of byte, halfword or word size into RAM bus cycles.
- Handles sub-word stores by read-modify-write and sub-word loads by lane extract plus sign or zero extension.
- Returns a one-cycle done pulse to the CPU control FSM.

Parameters:
- ADDR_W, 12, RAM word-address width; RAM depth is 2^ADDR_W words.
- BYTE_LITTLE, 1, lane order: 1 means byte 0 is Data[7:0]; 0 means byte 0 is Data[31:24].

Ports:
- CLK  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- req  in  1  start request; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
- sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address; bits [ADDR_W+1:2] select the word, higher bits ignored
- wdata  in  32  store data, right-aligned for sub-word stores
- rdata  out  32  load result, extended
- done  out  1  one-cycle completion pulse
- err  out  1  misalignment flag, valid while done=1
- busy  out  1  high in every state except IDLE
- ram_addr  out  ADDR_W  RAM word address
- ram_data  inout  32  RAM shared data bus
- ram_rw  out  1  1 = write, 0 = read; the RAM drives the bus whenever this is 0
- ram_cs  out  1  RAM chip select

Behaviour:
- Reset, asynchronous:
  - state = IDLE; rdata = 0; done = 0; err = 0; busy = 0.
  - ram_rw = 0; ram_cs = 0; ram_addr = 0; ram_data released (Z).
- Request latch: on req=1 in IDLE, latch we, size, sext, addr, wdata at the clock edge. Inputs are ignored in all other states.
- Misalignment:
  - Halfword with addr[0]=1, word with addr[1:0]≠0, or size=11 is misaligned.
  - A misaligned request goes IDLE→FAULT→IDLE. done=1 and err=1 in the FAULT cycle. rdata is unchanged. No RAM cycle is issued; ram_cs stays 0.
- States: IDLE, RD, WR, DONE, FAULT.
- State transitions:
  - Load: IDLE→RD→DONE→IDLE.
  - Word store: IDLE→WR→DONE→IDLE.
  - Sub-word store: IDLE→RD→WR→DONE→IDLE.
- RD state:
  - ram_cs=1, ram_rw=0, ram_addr=latched word index; the controller does not drive the bus.
  - At the closing edge, capture ram_data into an internal word register.
  - For loads, also load rdata with the extracted, extended lane.
- WR state:
  - ram_cs=1, ram_rw=1; ram_data driven with the merged word.
  - Word store: merged word = wdata.
  - Sub-word store: merged word = captured word with the addressed byte (addr[1:0]) or halfword (addr[1]) lane replaced by wdata[7:0] or wdata[15:0].
  - The RAM commits the write at the closing edge.
- DONE state: done=1, err=0; ram_cs=0, ram_rw=0; bus released.
- Latency from the accepting edge to the done cycle:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Fault: 1 cycle.
- Bus ownership:
  - ram_data is driven only while the registered state is WR; it is Z otherwise.
  - ram_rw is decoded only from the registered state, so the controller never drives the bus while ram_rw=0. This prevents contention.
- Extraction:
  - Byte lanes follow BYTE_LITTLE.
  - sext replicates bit 7 (byte) or bit 15 (halfword) into the upper bits; otherwise the upper bits are 0.
  - Word loads ignore sext.
- rdata holds its value until the next completed load or reset. Stores and faults do not modify it.
- Back-to-back: req held high is accepted again in the IDLE cycle after DONE. There is no request queue.
- Reset mid-operation: return to IDLE immediately and release the bus. An in-flight write is abandoned if reset precedes the WR closing edge.

Test Plan:
- Word store then load: store 0xDEADBEEF to addr 0x0000_0010, then load word from 0x10. Required: RAM word 4 = 0xDEADBEEF; rdata = 0xDEADBEEF; done 2 cycles after each accept; err=0.
- Byte store read-modify-write (BYTE_LITTLE=1): RAM word 4 = 0x11223344; store byte 0xAA to 0x12. Required: word 4 = 0x11AA3344; RD and WR visible on the bus; done 3 cycles after accept.
- Signed and unsigned halfword loads: word 4 = 0x8001_7FFF. Halfword load of 0x12 with sext=1 gives 0xFFFF8001. Same load with sext=0 gives 0x00008001. Halfword load of 0x10 with sext=1 gives 0x00007FFF.
- Misaligned request: word load from 0x13. Required: done=err=1 one cycle after accept; ram_cs never asserted; rdata unchanged.
- Bus ownership: monitor ram_data during a mixed sequence. Required: the controller drives only in WR cycles; no X on ram_data in any cycle.
- Reset mid-operation: assert Rst during the RD cycle of a sub-word store. Required: immediate IDLE; ram_cs=0; bus Z; RAM word unchanged; next request completes normally.
